// File: rtl/tlcd_bus_arbiter.sv
// tlcd_bus_arbiter: shares the Text LCD pin bus between two byte requesters with HD44780 write timing.
// Ports: CLK/RST (sync active-high); per port n: REQn, VALIDn, RSn, DATAn in, GNTn, READYn out;
// LCD side: TLCD_E, TLCD_RS, TLCD_RW (tied 0), TLCD_DATA; BUSY while a byte is in flight.
// Build option: define TLCD_RR_ARB_EN for round-robin tie breaking (default: port 0 wins ties).
module tlcd_bus_arbiter #(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 4,
  parameter int GAP_CYC      = 2000,
  parameter int LONG_GAP_CYC = 82000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       VALID0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  output logic       GNT0,
  output logic       READY0,
  input  logic       REQ1,
  input  logic       VALID1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  output logic       GNT1,
  output logic       READY1,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA,
  output logic       BUSY
);
  localparam int CW = $clog2(LONG_GAP_CYC + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, e_q, e_d, rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic idle, free, done, acc0, acc1, long_gap, pick0;
  assign idle = state_q == IDLE;
  assign free = idle & ~gnt0_q & ~gnt1_q;
  assign done = cnt_q == '0;
  assign READY0 = gnt0_q & idle;
  assign READY1 = gnt1_q & idle;
  assign acc0 = VALID0 & READY0;
  assign acc1 = VALID1 & READY1;
  // clear and return-home commands need the long execute wait
  assign long_gap = ~rs_q & (data_q == 8'h01 | data_q == 8'h02 | data_q == 8'h03);
`ifdef TLCD_RR_ARB_EN
  // ptr_q=1 means port 1 was granted last, so port 0 wins the next tie
  logic ptr_q, ptr_d;
  assign pick0 = REQ0 & (~REQ1 | ptr_q);
  assign ptr_d = free & (REQ0 | REQ1) ? ~pick0 : ptr_q;
  always_ff @(posedge CLK)
    ptr_q <= RST ? 1'b1 : ptr_d;
`else
  assign pick0 = REQ0;
`endif
  // an owner keeps the bus until it drops REQ while the engine is idle
  always_comb begin
    gnt0_d = free ? pick0 : gnt0_q & (REQ0 | ~idle);
    gnt1_d = free ? REQ1 & ~pick0 : gnt1_q & (REQ1 | ~idle);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = done ? cnt_q : cnt_q - 1'b1;
    e_d = e_q;
    rs_d = rs_q;
    data_d = data_q;
    if (idle) begin
      if (acc0 | acc1) begin
        state_d = SETUP;
        cnt_d = CW'(SETUP_CYC - 1);
        rs_d = acc0 ? RS0 : RS1;
        data_d = acc0 ? DATA0 : DATA1;
      end
    end else if (done) begin
      case (state_q)
        SETUP: begin
          state_d = PULSE;
          cnt_d = CW'(PULSE_CYC - 1);
          e_d = 1'b1;
        end
        PULSE: begin
          state_d = HOLD;
          cnt_d = CW'(HOLD_CYC - 1);
          e_d = 1'b0;
        end
        HOLD: begin
          state_d = GAP;
          cnt_d = long_gap ? CW'(LONG_GAP_CYC - 1) : CW'(GAP_CYC - 1);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      e_q <= 1'b0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      e_q <= e_d;
      rs_q <= rs_d;
      data_q <= data_d;
    end
  end
  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign TLCD_E = e_q;
  assign TLCD_RS = rs_q;
  assign TLCD_RW = 1'b0;
  assign TLCD_DATA = data_q;
  assign BUSY = ~idle;
endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// tb_tlcd_bus_arbiter: directed self-checking bench for tlcd_bus_arbiter.
module tb_tlcd_bus_arbiter;
  localparam int N = 40;
  localparam int L = 120;
`ifdef TLCD_RR_ARB_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif
  localparam int LS = 1 - W;
  logic CLK = 0, RST;
  logic REQ0, VALID0, RS0, REQ1, VALID1, RS1;
  logic [7:0] DATA0, DATA1;
  logic GNT0, READY0, GNT1, READY1, TLCD_E, TLCD_RS, TLCD_RW, BUSY;
  logic [7:0] TLCD_DATA;
  int errors = 0, checks = 0;
  tlcd_bus_arbiter #(.SETUP_CYC(4), .PULSE_CYC(12), .HOLD_CYC(4), .GAP_CYC(20), .LONG_GAP_CYC(100)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .VALID0(VALID0), .RS0(RS0), .DATA0(DATA0), .GNT0(GNT0), .READY0(READY0),
    .REQ1(REQ1), .VALID1(VALID1), .RS1(RS1), .DATA1(DATA1), .GNT1(GNT1), .READY1(READY1),
    .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic gnt(input int p);
    return p != 0 ? GNT1 : GNT0;
  endfunction
  function automatic logic rdy(input int p);
    return p != 0 ? READY1 : READY0;
  endfunction
  task automatic set_req(input int p, input logic v);
    if (p != 0) REQ1 = v;
    else REQ0 = v;
  endtask
  task automatic drv(input int p, input logic v, input logic rs, input logic [7:0] d);
    if (p != 0) begin
      VALID1 = v; RS1 = rs; DATA1 = d;
    end else begin
      VALID0 = v; RS0 = rs; DATA0 = d;
    end
  endtask
  // presents one byte to an idle owner and follows it through the full write cycle
  task automatic xfer(input int p, input logic rs, input logic [7:0] d, input int total, input bit drop);
    drv(p, 1'b1, rs, d);
    tick();
    drv(p, 1'b0, rs, d);
    if (drop) set_req(p, 1'b0);
    chk8("acc_data", TLCD_DATA, d);
    chk1("acc_rs", TLCD_RS, rs);
    chk1("acc_busy", BUSY, 1'b1);
    chk1("acc_ready", rdy(p), 1'b0);
    run(3);
    chk1("e_setup", TLCD_E, 1'b0);
    tick();
    chk1("e_rise", TLCD_E, 1'b1);
    run(11);
    chk1("e_high", TLCD_E, 1'b1);
    tick();
    chk1("e_fall", TLCD_E, 1'b0);
    chk8("hold_data", TLCD_DATA, d);
    run(total - 17);
    chk1("gap_ready", rdy(p), 1'b0);
    chk1("rw_low", TLCD_RW, 1'b0);
    tick();
    chk1("done_ready", rdy(p), 1'b1);
    chk1("done_busy", BUSY, 1'b0);
    chk8("done_data", TLCD_DATA, d);
  endtask
  initial begin
    RST = 1; REQ0 = 0; REQ1 = 0;
    drv(0, 1'b0, 1'b0, 8'h00);
    drv(1, 1'b0, 1'b0, 8'h00);
    run(2);
    chk1("rst_e", TLCD_E, 1'b0);
    chk1("rst_rs", TLCD_RS, 1'b0);
    chk1("rst_rw", TLCD_RW, 1'b0);
    chk8("rst_data", TLCD_DATA, 8'h00);
    chk1("rst_gnt0", GNT0, 1'b0);
    chk1("rst_gnt1", GNT1, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    RST = 0;
    // single byte from port 0, grant lags request by one cycle
    REQ0 = 1;
    drv(0, 1'b1, 1'b1, 8'h41);
    chk1("t1_gnt_same", GNT0, 1'b0);
    tick();
    chk1("t1_gnt0", GNT0, 1'b1);
    chk1("t1_gnt1", GNT1, 1'b0);
    chk1("t1_ready0", READY0, 1'b1);
    xfer(0, 1'b1, 8'h41, N, 0);
    // clear command takes the long gap, the same value as data does not
    xfer(0, 1'b0, 8'h01, L, 0);
    xfer(0, 1'b1, 8'h01, N, 0);
    xfer(0, 1'b0, 8'h03, L, 0);
    REQ0 = 0;
    tick();
    chk1("t2_drop_idle", GNT0, 1'b0);
    // simultaneous request: fixed priority picks 0, round-robin picks 1 after port 0's use
    REQ0 = 1; REQ1 = 1;
    tick();
    chk1("t3_win", gnt(W), 1'b1);
    chk1("t3_lose", gnt(LS), 1'b0);
    set_req(LS, 1'b0);
    xfer(W, 1'b1, 8'h31, N, 0);
    xfer(W, 1'b1, 8'h32, N, 0);
    set_req(LS, 1'b1);
    xfer(W, 1'b1, 8'h33, N, 1);
    chk1("t3_hold_owner", gnt(W), 1'b1);
    tick();
    chk1("t3_clear_w", gnt(W), 1'b0);
    chk1("t3_clear_l", gnt(LS), 1'b0);
    tick();
    chk1("t3_handoff", gnt(LS), 1'b1);
    chk1("t3_handoff_w", gnt(W), 1'b0);
    // the other port waits with a byte pending while the owner bursts
    set_req(W, 1'b1);
    drv(W, 1'b1, 1'b1, 8'hEE);
    xfer(LS, 1'b1, 8'h55, N, 0);
    chk1("t4_lock", gnt(W), 1'b0);
    xfer(LS, 1'b0, 8'h66, N, 0);
    chk1("t4_lock2", gnt(W), 1'b0);
    set_req(LS, 1'b0);
    tick();
    chk1("t4_gap_l", gnt(LS), 1'b0);
    chk1("t4_gap_w", gnt(W), 1'b0);
    chk8("t4_no_steal", TLCD_DATA, 8'h66);
    tick();
    chk1("t4_gnt_w", gnt(W), 1'b1);
    chk1("t4_ready_w", rdy(W), 1'b1);
    xfer(W, 1'b1, 8'hEE, N, 0);
    set_req(W, 1'b0);
    tick();
    chk1("t4_release", GNT0 | GNT1, 1'b0);
    // second tie: port 0 in both builds (round-robin last granted port 1 or W)
    REQ0 = 1; REQ1 = 1;
    tick();
    chk1("t6_tie_gnt0", GNT0, 1'b1);
    chk1("t6_tie_gnt1", GNT1, 1'b0);
    // reset in the middle of the enable pulse
    drv(0, 1'b1, 1'b1, 8'h77);
    tick();
    drv(0, 1'b0, 1'b1, 8'h77);
    run(5);
    chk1("t5_pulse", TLCD_E, 1'b1);
    RST = 1;
    tick();
    RST = 0;
    chk1("t5_e", TLCD_E, 1'b0);
    chk8("t5_data", TLCD_DATA, 8'h00);
    chk1("t5_gnt0", GNT0, 1'b0);
    chk1("t5_gnt1", GNT1, 1'b0);
    chk1("t5_busy", BUSY, 1'b0);
    tick();
    chk1("t5_regrant0", GNT0, 1'b1);
    chk1("t5_regrant1", GNT1, 1'b0);
    xfer(0, 1'b1, 8'h42, N, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlcd_bus_arbiter.md
Name: tlcd_bus_arbiter

Overview:
Shares the single Text LCD pin bus between two byte-stream requesters: port 0 is the custom font loader and port 1 is the text/screen writer. It replaces the static DONE-based output mux with request/grant arbitration and a valid/ready byte handshake. It generates HD44780-style write timing on TLCD_E, TLCD_RS, TLCD_RW and TLCD_DATA: setup, enable pulse, hold and execute gap. Requesters push bytes and no longer generate E timing themselves.

Parameters:
SETUP_CYC, 4, cycles that RS/DATA are stable before E rises (>=1)
PULSE_CYC, 12, E high width in cycles (>=1)
HOLD_CYC, 4, cycles that RS/DATA are held after E falls (>=1)
GAP_CYC, 2000, execute wait after a normal byte (>=1)
LONG_GAP_CYC, 82000, execute wait after a clear (0x01) or home (0x02/0x03) command with RS=0

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
REQ0  in  1  port 0 requests bus ownership
VALID0  in  1  port 0 byte valid
RS0  in  1  port 0 register select (0=command, 1=data)
DATA0  in  8  port 0 byte
GNT0  out  1  port 0 owns the bus
READY0  out  1  port 0 byte accepted this cycle when VALID0=1
REQ1, VALID1, RS1, DATA1, GNT1, READY1  same as port 0, for port 1
TLCD_E  out  1  LCD enable
TLCD_RS  out  1  LCD register select
TLCD_RW  out  1  LCD read/write; always 0
TLCD_DATA  out  8  LCD data bus
BUSY  out  1  a transfer is in flight (state != IDLE)

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All state updates happen on the CLK rising edge.
- Reset values: TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA=8'h00, GNT0=GNT1=0, BUSY=0, state=IDLE, counter=0.
- READYn is combinational: READYn = GNTn & (state==IDLE).
- Reset asserted mid-transfer aborts the transfer: TLCD_E=0 at the next edge, the byte is dropped and ownership is cleared.
- FSM states: IDLE, SETUP, PULSE, HOLD, GAP. A single down-counter is sized by $clog2(LONG_GAP_CYC+1).
- Arbitration (IDLE, no owner):
  - If REQ0=1, set GNT0 at the next edge.
  - Otherwise, if REQ1=1, set GNT1 at the next edge.
  - On a simultaneous request, port 0 wins.
  - GNT goes high one cycle after REQ, never in the same cycle.
- Ownership:
  - GNTn stays high while REQn=1. Bytes from the owner stream back-to-back, so the lock holds across multi-byte bursts.
  - If REQn drops while state!=IDLE, the transfer completes through GAP. GNTn clears on the first IDLE edge.
  - If REQn drops in IDLE, GNTn clears at the next edge.
  - At least one cycle with both GNT low separates owner changes. GNT0 and GNT1 are never both high.
- Accept: at an edge where VALIDn & READYn:
  - Latch RSn/DATAn onto TLCD_RS/TLCD_DATA at that same edge.
  - Set state=SETUP and BUSY=1.
  - VALID from a non-owner is ignored. No byte is lost: it is simply not accepted until granted.
- Timing, with accept edge = T:
  - TLCD_E rises at T+SETUP_CYC and falls at T+SETUP_CYC+PULSE_CYC.
  - HOLD lasts HOLD_CYC cycles. TLCD_RS/DATA are unchanged from T until the end of HOLD.
  - GAP length is LONG_GAP_CYC if the latched RS=0 and DATA in {8'h01, 8'h02, 8'h03}; otherwise it is GAP_CYC.
  - State returns to IDLE, and READY re-asserts, at T+SETUP_CYC+PULSE_CYC+HOLD_CYC+gap.
- TLCD_RS/DATA keep their last values in IDLE and GAP. They change only on accept.
- The arbiter never drives TLCD_RW=1. Busy-flag polling is not supported; fixed gaps are used instead.

Optional Feature:
TLCD_RR_ARB_EN:
- When defined, arbitration is round-robin. A 1-bit pointer records the last granted port. On a simultaneous REQ0/REQ1 in IDLE with no owner, the port other than the last granted one wins. The pointer resets to 1, so port 0 wins first.
- When not defined, fixed priority applies: port 0 always wins ties. There is no pointer register.
- Lock and handshake behaviour are identical in both builds.

Test Plan:
1. Reset, then REQ0=1 and VALID0=1, RS0=1, DATA0=8'h41 -> GNT0=1 one cycle later. Accept at T. TLCD_DATA=8'h41 and TLCD_RS=1 from T. E high over [T+4, T+16). READY0 high again at T+2020. TLCD_RW=0 throughout.
2. Port 0 sends RS0=0, DATA0=8'h01 -> LONG gap applies: READY0 re-asserts at T+82020. An RS0=1, DATA0=8'h01 byte instead gets the short gap: T+2020.
3. REQ0 and REQ1 rise in the same cycle -> GNT0 granted and GNT1 stays 0. After port 0 sends 3 bytes and drops REQ0: GNT0 clears, there is 1 cycle with both GNT low, then GNT1=1.
4. Port 1 is owner and REQ0 rises mid-burst -> GNT1 holds until REQ1 drops. VALID0 is never accepted while GNT0=0, and TLCD_DATA shows only port 1 bytes.
5. Assert RST during PULSE (TLCD_E=1) -> at the next edge TLCD_E=0, DATA=8'h00, GNT0=GNT1=0, BUSY=0. A new request is then granted normally.
6. With TLCD_RR_ARB_EN defined: a simultaneous request after port 0's burst -> port 1 wins. The next tie -> port 0 wins.
